// File: rtl/gray_onehot_seq.sv
// Index sequencer feeding a 3-bit gray / one-hot encoder, with the registered code
// presented on a valid/ready stream. Mode, direction and wrap are latched per pass.
module gray_onehot_seq #(
    parameter int unsigned LAST         = 7,
    parameter bit          CONT_DEFAULT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       mode_sel,
    input  logic       dir,
    input  logic       cont,
    input  logic       out_ready,
    output logic [2:0] idx,
    output logic [6:0] code_out,
    output logic       out_valid,
    output logic       mode_q,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [2:0] LastIdx = 3'(LAST);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [6:0] code_q, code_d;
    logic       mode_d;
    logic       dir_q, dir_d;
    logic       cont_q, cont_d;
    logic       stop_q, stop_d;
    logic       at_end;

    function automatic logic [6:0] encode(input logic [2:0] i, input logic gray);
        logic [6:0] c;
        c = '0;
        if (gray) begin
            c[2:0] = {i[2], i[2] ^ i[1], i[1] ^ i[0]};
        end else if (i != 3'd0) begin
            c[i - 3'd1] = 1'b1;
        end
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        code_d  = code_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        cont_d  = cont_q;
        stop_d  = stop_q;
        at_end  = dir_q ? (idx_q == LastIdx) : (idx_q == 3'd0);

        unique case (state_q)
            StIdle: begin
                idx_d  = 3'd0;
                code_d = '0;
                stop_d = 1'b0;
                if (start) begin
                    state_d = StRun;
                    mode_d  = mode_sel;
                    dir_d   = dir;
                    cont_d  = cont;
                    idx_d   = dir ? 3'd0 : LastIdx;
                    code_d  = encode(idx_d, mode_sel);
                end
            end
            StRun: begin
                // A stop seen during a stall is remembered until the held beat is taken.
                if (stop) stop_d = 1'b1;
                if (out_ready) begin
                    if (at_end && !cont_q) begin
                        state_d = StDone;
                        idx_d   = 3'd0;
                        code_d  = '0;
                    end else if (stop || stop_q) begin
                        state_d = StIdle;
                        idx_d   = 3'd0;
                        code_d  = '0;
                    end else begin
                        if (at_end) begin
                            idx_d = dir_q ? 3'd0 : LastIdx;
                        end else begin
                            idx_d = dir_q ? idx_q + 3'd1 : idx_q - 3'd1;
                        end
                        code_d = encode(idx_d, mode_q);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                idx_d   = 3'd0;
                code_d  = '0;
            end
            default: begin
                state_d = StIdle;
                idx_d   = 3'd0;
                code_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            code_q  <= '0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            cont_q  <= CONT_DEFAULT;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            cont_q  <= cont_d;
            stop_q  <= stop_d;
        end
    end

    assign idx       = idx_q;
    assign code_out  = code_q;
    assign out_valid = (state_q == StRun);
    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);

endmodule
